// File: rtl/rob_pkg.sv
// rob_pkg: shared types, default sizes and index-width helper for the banked ROB
package rob_pkg;
  localparam int ROB_ROWS_DEF = 16;
  localparam int BANKS_DEF = 2;
  localparam int WB_PORTS_DEF = 2;
  localparam int PHYS_W = 6;
  localparam int ARCH_W = 5;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int ROW_W = idx_w(ROB_ROWS_DEF);
  localparam int BANK_W = idx_w(BANKS_DEF);
  typedef struct packed {
    logic entry_valid;
    logic done;
    logic [ARCH_W-1:0] arch_rd;
    logic [PHYS_W-1:0] phys_rd;
  } rob_entry_t;
endpackage

// File: rtl/rob_banked_if.sv
// rob_banked_if: dispatch, writeback, lookup, commit and flush signals of the banked ROB
interface rob_banked_if
  import rob_pkg::*;
#(
  parameter int ROB_ROWS = ROB_ROWS_DEF,
  parameter int BANKS = BANKS_DEF,
  parameter int WB_PORTS = WB_PORTS_DEF
);
  localparam int RW = idx_w(ROB_ROWS);
  localparam int BW = idx_w(BANKS);
  logic [BANKS-1:0] disp_valid;
  logic disp_ready;
  logic [BANKS*ARCH_W-1:0] disp_arch_rd;
  logic [BANKS*PHYS_W-1:0] disp_phys_rd;
  logic [RW-1:0] disp_row;
  logic [WB_PORTS-1:0] wb_en;
  logic [WB_PORTS*RW-1:0] wb_row;
  logic [WB_PORTS*BW-1:0] wb_bank;
  logic [BANKS*ARCH_W-1:0] lk_rs1, lk_rs2;
  logic [BANKS-1:0] lk_hit1, lk_hit2;
  logic [BANKS*PHYS_W-1:0] lk_phys1, lk_phys2;
  logic [BANKS-1:0] lk_done1, lk_done2;
  logic [BANKS-1:0] commit_en;
  logic [BANKS*ARCH_W-1:0] commit_arch_rd;
  logic [BANKS*PHYS_W-1:0] commit_phys_rd;
  logic flush;
  logic empty;
  modport master (
    output disp_valid, disp_arch_rd, disp_phys_rd, wb_en, wb_row, wb_bank, lk_rs1, lk_rs2, flush,
    input disp_ready, disp_row, lk_hit1, lk_hit2, lk_phys1, lk_phys2, lk_done1, lk_done2,
    input commit_en, commit_arch_rd, commit_phys_rd, empty
  );
  modport slave (
    input disp_valid, disp_arch_rd, disp_phys_rd, wb_en, wb_row, wb_bank, lk_rs1, lk_rs2, flush,
    output disp_ready, disp_row, lk_hit1, lk_hit2, lk_phys1, lk_phys2, lk_done1, lk_done2,
    output commit_en, commit_arch_rd, commit_phys_rd, empty
  );
endinterface

// File: rtl/rob_lookup.sv
// rob_lookup: youngest-match age-priority search for one source operand
module rob_lookup
  import rob_pkg::*;
#(
  parameter int ROB_ROWS = ROB_ROWS_DEF,
  parameter int BANKS = BANKS_DEF
) (
  input rob_entry_t ent_i [ROB_ROWS][BANKS],
  input logic [idx_w(ROB_ROWS)-1:0] tail_i,
  input logic [ARCH_W-1:0] src_i,
  output logic hit_o,
  output logic [PHYS_W-1:0] phys_o,
  output logic done_o
);
  localparam int RW = idx_w(ROB_ROWS);
  // Walk oldest to youngest (row distance from tail, then bank) so the last match is the youngest
  always_comb begin
    hit_o = 1'b0;
    phys_o = '0;
    done_o = 1'b0;
    for (int a = 0; a < ROB_ROWS; a++)
      for (int b = 0; b < BANKS; b++)
        if (src_i != '0 && ent_i[tail_i + RW'(a)][b].entry_valid && ent_i[tail_i + RW'(a)][b].arch_rd == src_i) begin
          hit_o = 1'b1;
          phys_o = ent_i[tail_i + RW'(a)][b].phys_rd;
          done_o = ent_i[tail_i + RW'(a)][b].done;
        end
  end
endmodule

// File: rtl/rob_banked.sv
// rob_banked: row-granular banked reorder buffer with wrap-bit pointers, lookup and flush
module rob_banked
  import rob_pkg::*;
#(
  parameter int ROB_ROWS = ROB_ROWS_DEF,
  parameter int BANKS = BANKS_DEF,
  parameter int WB_PORTS = WB_PORTS_DEF
) (
  input logic clk,
  input logic rst,
  rob_banked_if.slave bus
);
  localparam int RW = idx_w(ROB_ROWS);
  localparam int BW = idx_w(BANKS);
  rob_entry_t ent_q [ROB_ROWS][BANKS];
  rob_entry_t ent_d [ROB_ROWS][BANKS];
  logic [RW:0] head_q, head_d, tail_q, tail_d, count;
  logic [BANKS-1:0] cen_q, cen_d;
  logic [BANKS*ARCH_W-1:0] carch_q, carch_d;
  logic [BANKS*PHYS_W-1:0] cphys_q, cphys_d;
  logic [RW-1:0] hidx, tidx;
  logic full, empty, fire, commit, row_done;
  logic [BANKS-1:0] hit1, hit2, done1, done2;
  logic [BANKS*PHYS_W-1:0] phys1, phys2;
  assign hidx = head_q[RW-1:0];
  assign tidx = tail_q[RW-1:0];
  assign count = head_q - tail_q;
  assign full = count == {1'b1, {RW{1'b0}}};
  assign empty = count == '0;
  assign bus.disp_ready = !full && !bus.flush;
  assign bus.disp_row = hidx;
  assign bus.empty = empty;
  assign fire = bus.disp_ready && |bus.disp_valid;
  assign commit = !empty && row_done && !bus.flush;
  assign bus.commit_en = cen_q;
  assign bus.commit_arch_rd = carch_q;
  assign bus.commit_phys_rd = cphys_q;
  assign bus.lk_hit1 = hit1;
  assign bus.lk_hit2 = hit2;
  assign bus.lk_phys1 = phys1;
  assign bus.lk_phys2 = phys2;
  assign bus.lk_done1 = done1;
  assign bus.lk_done2 = done2;
  // Tail row is retirable once every lane that was dispatched has written back
  always_comb begin
    row_done = 1'b1;
    for (int b = 0; b < BANKS; b++)
      if (ent_q[tidx][b].entry_valid && !ent_q[tidx][b].done) row_done = 1'b0;
  end
  // Next state: writeback, then commit clears tail row, then dispatch fills head row; flush overrides all
  always_comb begin
    ent_d = ent_q;
    head_d = head_q;
    tail_d = tail_q;
    cen_d = '0;
    carch_d = carch_q;
    cphys_d = cphys_q;
    for (int k = 0; k < WB_PORTS; k++)
      if (bus.wb_en[k] && ent_q[bus.wb_row[k*RW +: RW]][bus.wb_bank[k*BW +: BW]].entry_valid)
        ent_d[bus.wb_row[k*RW +: RW]][bus.wb_bank[k*BW +: BW]].done = 1'b1;
    if (commit) begin
      for (int b = 0; b < BANKS; b++) begin
        cen_d[b] = ent_q[tidx][b].entry_valid;
        carch_d[b*ARCH_W +: ARCH_W] = ent_q[tidx][b].arch_rd;
        cphys_d[b*PHYS_W +: PHYS_W] = ent_q[tidx][b].phys_rd;
        ent_d[tidx][b] = '0;
      end
      tail_d = tail_q + 1'b1;
    end
    if (fire) begin
      for (int b = 0; b < BANKS; b++)
        ent_d[hidx][b] = '{entry_valid: bus.disp_valid[b], done: 1'b0,
                           arch_rd: bus.disp_arch_rd[b*ARCH_W +: ARCH_W],
                           phys_rd: bus.disp_phys_rd[b*PHYS_W +: PHYS_W]};
      head_d = head_q + 1'b1;
    end
    if (bus.flush) begin
      for (int r = 0; r < ROB_ROWS; r++)
        for (int b = 0; b < BANKS; b++)
          ent_d[r][b] = '0;
      head_d = '0;
      tail_d = '0;
      cen_d = '0;
    end
  end
  // State registers; reset acts as a flush that also clears the commit mapping
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROB_ROWS; r++)
        for (int b = 0; b < BANKS; b++)
          ent_q[r][b] <= '0;
      head_q <= '0;
      tail_q <= '0;
      cen_q <= '0;
      carch_q <= '0;
      cphys_q <= '0;
    end else begin
      ent_q <= ent_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cen_q <= cen_d;
      carch_q <= carch_d;
      cphys_q <= cphys_d;
    end
  end
  for (genvar l = 0; l < BANKS; l++) begin : g_lk
    rob_lookup #(.ROB_ROWS(ROB_ROWS), .BANKS(BANKS)) u_lk1 (
      .ent_i(ent_q), .tail_i(tidx), .src_i(bus.lk_rs1[l*ARCH_W +: ARCH_W]),
      .hit_o(hit1[l]), .phys_o(phys1[l*PHYS_W +: PHYS_W]), .done_o(done1[l])
    );
    rob_lookup #(.ROB_ROWS(ROB_ROWS), .BANKS(BANKS)) u_lk2 (
      .ent_i(ent_q), .tail_i(tidx), .src_i(bus.lk_rs2[l*ARCH_W +: ARCH_W]),
      .hit_o(hit2[l]), .phys_o(phys2[l*PHYS_W +: PHYS_W]), .done_o(done2[l])
    );
  end
endmodule

// File: tb/tb_rob_banked.sv
// tb_rob_banked: directed self-checking bench for rob_banked
module tb_rob_banked;
  import rob_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  rob_banked_if bus ();
  rob_banked dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    bus.disp_valid = '0;
    bus.disp_arch_rd = '0;
    bus.disp_phys_rd = '0;
    bus.wb_en = '0;
    bus.wb_row = '0;
    bus.wb_bank = '0;
    bus.flush = 1'b0;
  endtask
  task automatic disp(input logic [1:0] v, input logic [4:0] a0, input logic [5:0] p0,
                      input logic [4:0] a1, input logic [5:0] p1);
    bus.disp_valid = v;
    bus.disp_arch_rd = {a1, a0};
    bus.disp_phys_rd = {p1, p0};
  endtask
  task automatic wb(input logic [1:0] en, input logic [3:0] r0, input logic b0,
                    input logic [3:0] r1, input logic b1);
    bus.wb_en = en;
    bus.wb_row = {r1, r0};
    bus.wb_bank = {b1, b0};
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  initial begin
    logic [3:0] r;
    logic [4:0] a0, a1;
    logic [5:0] p0, p1;
    idle;
    bus.lk_rs1 = '0;
    bus.lk_rs2 = '0;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    #1;
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_ready", 32'(bus.disp_ready), 1);
    chk("rst_cen", 32'(bus.commit_en), 0);
    chk("rst_carch", 32'(bus.commit_arch_rd), 0);
    chk("rst_cphys", 32'(bus.commit_phys_rd), 0);
    disp(2'b11, 5'd1, 6'd10, 5'd2, 6'd11);
    #1;
    chk("d0_row", 32'(bus.disp_row), 0);
    tick;
    disp(2'b01, 5'd3, 6'd12, 5'd0, 6'd0);
    #1;
    chk("d1_row", 32'(bus.disp_row), 1);
    tick;
    idle;
    bus.lk_rs1 = {5'd3, 5'd1};
    #1;
    chk("d_empty", 32'(bus.empty), 0);
    chk("lk_x1_hit", 32'(bus.lk_hit1[0]), 1);
    chk("lk_x1_phys", 32'(bus.lk_phys1[5:0]), 10);
    chk("lk_x3_phys", 32'(bus.lk_phys1[11:6]), 12);
    chk("lk_x3_done", 32'(bus.lk_done1[1]), 0);
    tick;
    chk("no_commit", 32'(bus.commit_en), 0);
    wb(2'b01, 4'd1, 1'b0, 4'd0, 1'b0);
    tick;
    idle;
    #1;
    chk("lk_x3_done_wb", 32'(bus.lk_done1[1]), 1);
    tick;
    chk("no_commit_row0", 32'(bus.commit_en), 0);
    wb(2'b11, 4'd0, 1'b0, 4'd0, 1'b1);
    tick;
    idle;
    chk("commit_latency", 32'(bus.commit_en), 0);
    tick;
    chk("c0_en", 32'(bus.commit_en), 2'b11);
    chk("c0_arch", 32'(bus.commit_arch_rd), {5'd2, 5'd1});
    chk("c0_phys", 32'(bus.commit_phys_rd), {6'd11, 6'd10});
    tick;
    chk("c1_en", 32'(bus.commit_en), 2'b01);
    chk("c1_arch", 32'(bus.commit_arch_rd[4:0]), 3);
    chk("c1_phys", 32'(bus.commit_phys_rd[5:0]), 12);
    chk("c1_empty", 32'(bus.empty), 1);
    tick;
    chk("c_idle", 32'(bus.commit_en), 0);
    for (int i = 0; i < 16; i++) begin
      r = 4'(2 + i);
      a0 = (r == 4'd7) ? 5'd5 : 5'd8;
      p0 = (r == 4'd7) ? 6'd21 : 6'(r);
      a1 = (r == 4'd3) ? 5'd5 : 5'd9;
      p1 = (r == 4'd3) ? 6'd20 : 6'(r) + 6'd16;
      disp(2'b11, a0, p0, a1, p1);
      #1;
      chk("fill_row", 32'(bus.disp_row), 32'(r));
      tick;
    end
    chk("full_ready", 32'(bus.disp_ready), 0);
    chk("full_empty", 32'(bus.empty), 0);
    tick;
    idle;
    bus.lk_rs1 = {5'd0, 5'd5};
    bus.lk_rs2 = {5'd9, 5'd0};
    #1;
    chk("lk_x5_hit", 32'(bus.lk_hit1[0]), 1);
    chk("lk_x5_phys", 32'(bus.lk_phys1[5:0]), 21);
    chk("lk_x9_phys", 32'(bus.lk_phys2[11:6]), 17);
    chk("lk_x0_hit", 32'(bus.lk_hit2[0]), 0);
    chk("lk_x0_phys", 32'(bus.lk_phys2[5:0]), 0);
    wb(2'b11, 4'd2, 1'b0, 4'd2, 1'b1);
    tick;
    idle;
    disp(2'b11, 5'd4, 6'd40, 5'd4, 6'd41);
    #1;
    chk("full_commit_ready", 32'(bus.disp_ready), 0);
    tick;
    chk("wrap_c_en", 32'(bus.commit_en), 2'b11);
    chk("wrap_c_arch", 32'(bus.commit_arch_rd), {5'd9, 5'd8});
    chk("wrap_c_phys", 32'(bus.commit_phys_rd), {6'd18, 6'd2});
    chk("wrap_ready", 32'(bus.disp_ready), 1);
    chk("wrap_row", 32'(bus.disp_row), 2);
    tick;
    idle;
    #1;
    chk("refull_ready", 32'(bus.disp_ready), 0);
    chk("refull_cen", 32'(bus.commit_en), 0);
    wb(2'b11, 4'd3, 1'b0, 4'd3, 1'b1);
    tick;
    wb(2'b11, 4'd4, 1'b0, 4'd4, 1'b1);
    tick;
    wb(2'b11, 4'd5, 1'b0, 4'd5, 1'b1);
    tick;
    idle;
    tick;
    chk("adv_cphys", 32'(bus.commit_phys_rd), {6'd21, 6'd5});
    disp(2'b11, 5'd5, 6'd30, 5'd9, 6'd34);
    #1;
    chk("wrap_row3", 32'(bus.disp_row), 3);
    tick;
    disp(2'b11, 5'd6, 6'd36, 5'd6, 6'd37);
    #1;
    chk("wrap_row4", 32'(bus.disp_row), 4);
    tick;
    disp(2'b11, 5'd5, 6'd35, 5'd5, 6'd31);
    #1;
    chk("wrap_row5", 32'(bus.disp_row), 5);
    tick;
    idle;
    bus.lk_rs1 = {5'd0, 5'd5};
    bus.lk_rs2 = {5'd4, 5'd0};
    #1;
    chk("lk2_x5_hit", 32'(bus.lk_hit1[0]), 1);
    chk("lk2_x5_phys", 32'(bus.lk_phys1[5:0]), 31);
    chk("lk2_x5_done", 32'(bus.lk_done1[0]), 0);
    chk("lk2_x0_hit", 32'(bus.lk_hit2[0]), 0);
    chk("lk2_x4_phys", 32'(bus.lk_phys2[11:6]), 41);
    chk("lk2_full", 32'(bus.disp_ready), 0);
    wb(2'b11, 4'd6, 1'b0, 4'd6, 1'b1);
    tick;
    bus.flush = 1'b1;
    disp(2'b11, 5'd1, 6'd1, 5'd1, 6'd1);
    wb(2'b11, 4'd7, 1'b0, 4'd7, 1'b1);
    #1;
    chk("flush_ready", 32'(bus.disp_ready), 0);
    tick;
    idle;
    #1;
    chk("flush_empty", 32'(bus.empty), 1);
    chk("flush_cen", 32'(bus.commit_en), 0);
    chk("flush_lk", 32'(bus.lk_hit1), 0);
    chk("flush_row", 32'(bus.disp_row), 0);
    disp(2'b11, 5'd1, 6'd1, 5'd2, 6'd2);
    #1;
    chk("post_flush_row", 32'(bus.disp_row), 0);
    tick;
    idle;
    chk("post_flush_cen", 32'(bus.commit_en), 0);
    wb(2'b11, 4'd0, 1'b0, 4'd0, 1'b1);
    tick;
    idle;
    bus.lk_rs1 = {5'd2, 5'd1};
    #1;
    chk("pre_rst_hit", 32'(bus.lk_hit1), 2'b11);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    chk("rst_mid_cen", 32'(bus.commit_en), 0);
    chk("rst_mid_carch", 32'(bus.commit_arch_rd), 0);
    chk("rst_mid_cphys", 32'(bus.commit_phys_rd), 0);
    chk("rst_mid_empty", 32'(bus.empty), 1);
    chk("rst_mid_lk", 32'(bus.lk_hit1), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
